if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the pipelined core; sits directly upstream of the synchronous-read instruction memory.
- Owns the fetch PC and drives the memory address and memory hold.
- Tracks the one-cycle read latency, so each returned word is paired with its PC.
- Presents instructions to decode with a valid/ready handshake; applies branch/jump redirects with wrong-path kill.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset (word-aligned).
- CNT_W, 32, width of the fetched-instruction performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- imem_addr  out  32  byte address to instruction memory; combinational
- imem_stall  out  1  memory hold; when 1, memory keeps its data output
- imem_data  in  32  memory read data; valid one cycle after address
- redirect_valid  in  1  taken branch/jump/trap from EX
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- id_ready  in  1  decode can accept this cycle
- id_valid  out  1  id_inst/id_pc hold a live instruction
- id_inst  out  32  instruction word
- id_pc  out  32  PC of id_inst
- fetch_count  out  CNT_W  count of accepted instructions (id_valid & id_ready)

Behaviour:

Registers:
- pc_f: next PC to request.
- pc_d: PC of the in-flight/returned word.
- vld_d: returned word is live.
- fetch_count.

Reset (async, rst=1):
- pc_f=RESET_PC, pc_d=RESET_PC, vld_d=0, fetch_count=0.
- Outputs during reset: id_valid=0, imem_stall=0, imem_addr=RESET_PC.
- The memory returns NOP while in reset. That data is never marked valid.

Combinational outputs:
- id_valid = vld_d & ~redirect_valid. A redirect kills the word currently at decode.
- id_inst = imem_data; id_pc = pc_d.
- stall = vld_d & ~id_ready & ~redirect_valid.
- imem_stall = stall.
- imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : pc_f.

Per-cycle update, in priority order:
1. redirect_valid=1 (overrides stall):
   - pc_d <= aligned redirect_pc; pc_f <= aligned redirect_pc + 4; vld_d <= 1.
   - The target instruction appears at decode the next cycle. Exactly one bubble (the redirect cycle).
2. stall=1: pc_f, pc_d, vld_d hold. The memory holds its data, so id_inst is stable.
3. Otherwise: pc_d <= pc_f; pc_f <= pc_f + 4; vld_d <= 1.

PC arithmetic:
- Modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- pc_f and pc_d bits [1:0] are always 0.

fetch_count:
- Increments when id_valid & id_ready. Wraps modulo 2^CNT_W.
- Never increments in a redirect cycle.

Latency and throughput:
- First valid instruction (PC=RESET_PC) at decode in the 2nd cycle after reset deassert.
- Steady state: one instruction per cycle while id_ready=1.

Boundary cases:
- Stall and redirect in the same cycle: redirect wins; the stalled word is dropped, not counted.
- Back-to-back redirects: each cycle's target replaces the previous; only the last target's word becomes valid.
- id_ready=0 while vld_d=0: no stall; fetch advances.
- Reset asserted mid-stream or mid-stall: immediate return to reset state, in-flight word discarded. After deassert, fetch restarts at RESET_PC.
- id_inst/id_pc may change only when id_valid=0 or the previous cycle accepted/redirected. Never while id_valid & ~id_ready.

Test Plan:
1. Reset release, id_ready=1, memory preloaded with word k = 32'h1000_0000+k:
   - Cycle 1: id_valid=0.
   - Cycles 2..5: id_pc = 0,4,8,C with matching id_inst.
   - fetch_count=4 after cycle 5.
2. Decode backpressure: id_ready=0 for 3 cycles while id_pc=8:
   - imem_stall=1, id_pc=8 and id_inst stable all 3 cycles; fetch_count unchanged.
   - Release: next id_pc=C, with no skip and no duplicate.
3. Redirect: redirect_valid=1, redirect_pc=32'h0000_0103 while id_pc=10:
   - That cycle: id_valid=0 and imem_addr=100.
   - Next cycles: id_pc=100, then 104. No PC 14 ever accepted.
4. Redirect coincident with stall (id_ready=0, vld_d=1), target 200:
   - imem_stall=0; next cycle id_pc=200, id_valid=1.
   - The stalled word is not counted.
5. Wrap: redirect to FFFF_FFF8:
   - id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. Async reset asserted mid-stall at id_pc=40, without a clock edge:
   - id_valid drops to 0 immediately.
   - After deassert, the first accepted id_pc is RESET_PC and fetch_count restarts from 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Purpose : instruction-fetch stage; owns the fetch PC and pairs each word returned by the synchronous-read imem with its PC.
// Latency : one cycle from address to decode; the first word reaches decode in the 2nd cycle after reset release, then one per cycle.
// Backpr. : a held (valid, not ready) word freezes the PCs and holds the memory output; a redirect overrides the hold and kills that word.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   imem_addr / imem_stall      byte address and output-hold to the instruction memory (both combinational)
//   imem_data                   read data, valid one cycle after imem_addr
//   redirect_valid/redirect_pc  taken branch/jump/trap from EX; target bits [1:0] are ignored
//   id_valid/id_ready           valid/ready handshake towards decode
//   id_inst / id_pc             instruction word and its PC
//   fetch_count                 number of words accepted by decode, wraps modulo 2^CNT_W
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    output logic             imem_stall,
    input  logic [31:0]      imem_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [CNT_W-1:0] fetch_count
);

    // Force word alignment so the low PC bits stay zero even for an odd parameter value.
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] PC_STEP     = 32'd4;

    // pc_f : next address to request from memory.
    // pc_d : address of the word currently coming out of memory (at decode).
    // vld_d: that word belongs to the live instruction stream.
    logic [31:0]      pc_f;
    logic [31:0]      pc_d;
    logic             vld_d;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]      redir_pc_al;
    logic             stall;
    logic             accept;

    assign redir_pc_al = {redirect_pc[31:2], 2'b00};

    // Hold only when a live word is refused by decode. A redirect makes that
    // word wrong-path, so there is nothing worth holding on to.
    assign stall  = vld_d & ~id_ready & ~redirect_valid;

    // The word at decode is killed in the cycle a redirect arrives.
    assign id_valid = vld_d & ~redirect_valid;
    assign accept   = id_valid & id_ready;

    assign id_inst = imem_data;
    assign id_pc   = pc_d;

    // The redirect target is sent to memory in the same cycle, so it is at
    // decode one cycle later: exactly one bubble per redirect.
    assign imem_stall = stall;
    assign imem_addr  = redirect_valid ? redir_pc_al : pc_f;

    assign fetch_count = cnt_q;

    // PC pipeline. Redirect outranks stall; otherwise advance sequentially.
    // Additions are 32-bit and wrap naturally from FFFF_FFFC to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f  <= RESET_PC_AL;
            pc_d  <= RESET_PC_AL;
            vld_d <= 1'b0;
        end else if (redirect_valid) begin
            pc_d  <= redir_pc_al;
            pc_f  <= redir_pc_al + PC_STEP;
            vld_d <= 1'b1;
        end else if (!stall) begin
            pc_d  <= pc_f;
            pc_f  <= pc_f + PC_STEP;
            vld_d <= 1'b1;
        end
    end

    // accept already excludes redirect cycles through id_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule
